// File: rtl/mbist_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mbist_march_ctrl
// Purpose  : March C- MBIST controller for one single-port synchronous SRAM.
//            Optional MBIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
// Revision : 1.0
// ============================================================================
module mbist_march_ctrl #(
    parameter int pADDR_WIDTH = 4,
    parameter int pDATA_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [pADDR_WIDTH-1:0] fail_addr,
    output logic [pDATA_WIDTH-1:0] fail_data,
    output logic [7:0]             fail_count,
    output logic                   mem_cs,
    output logic                   mem_we,
    output logic [pADDR_WIDTH-1:0] mem_addr,
    output logic [pDATA_WIDTH-1:0] mem_din,
    input  logic [pDATA_WIDTH-1:0] mem_dout
);

`ifdef MBIST_STOP_ON_FAIL_EN
    localparam logic c_STOP_ON_FAIL = 1'b1;
`else
    localparam logic c_STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [pADDR_WIDTH-1:0] c_ADDR_LAST = '1;
    localparam logic [pADDR_WIDTH-1:0] c_ADDR_ONE  = pADDR_WIDTH'(1);
    localparam logic [2:0]             c_ELEM_LAST = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Elements 3 and 4 walk the address space downwards.
    function automatic logic elem_down(input logic [2:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    // M0 (w0) and M5 (r0) have one op per address; the rest are (read, write).
    function automatic logic elem_dual(input logic [2:0] e);
        return (e != 3'd0) && (e != c_ELEM_LAST);
    endfunction

    // Data bit of an op: write value for writes, expected value for reads.
    function automatic logic op_value(input logic [2:0] e, input logic o);
        case (e)
            3'd1, 3'd3: return o;
            3'd2, 3'd4: return ~o;
            default:    return 1'b0;
        endcase
    endfunction

    state_t                   state_q, state_d;
    logic [2:0]               elem_q, elem_d;
    logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                     op_q, op_d;

    logic                     mem_cs_q, mem_cs_d;
    logic                     mem_we_q, mem_we_d;
    logic [pADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [pDATA_WIDTH-1:0]   mem_din_q, mem_din_d;

    logic                     chk_vld_q;
    logic                     chk_exp_q;
    logic [pADDR_WIDTH-1:0]   chk_addr_q;

    logic                     fail_q, fail_d;
    logic [pADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
    logic [pDATA_WIDTH-1:0]   fail_data_q, fail_data_d;
    logic [7:0]               fail_count_q, fail_count_d;

    logic [2:0]               nxt_elem;
    logic [pADDR_WIDTH-1:0]   nxt_addr;
    logic                     nxt_op;
    logic                     w_elem_end;
    logic                     w_last_op;
    logic                     w_cmp;
    logic                     w_mismatch;
    logic                     w_issue;
    logic                     w_start_acc;
    logic                     w_wr;

    assign w_elem_end = elem_down(elem_q) ? (addr_q == '0) : (addr_q == c_ADDR_LAST);
    assign w_last_op  = (elem_q == c_ELEM_LAST) && (addr_q == c_ADDR_LAST);

    // The read data register of the SRAM holds across writes, so the compare
    // for a read issued last cycle is valid regardless of the current op.
    assign w_cmp      = chk_vld_q && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign w_mismatch = w_cmp && (mem_dout != {pDATA_WIDTH{chk_exp_q}});

    always_comb begin
        nxt_elem = elem_q;
        nxt_addr = addr_q;
        nxt_op   = 1'b0;
        if (elem_dual(elem_q) && !op_q) begin
            nxt_op = 1'b1;
        end else if (w_elem_end) begin
            nxt_elem = elem_q + 3'd1;
            nxt_addr = elem_down(elem_q + 3'd1) ? c_ADDR_LAST : '0;
        end else if (elem_down(elem_q)) begin
            nxt_addr = addr_q - c_ADDR_ONE;
        end else begin
            nxt_addr = addr_q + c_ADDR_ONE;
        end
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        op_d        = op_q;
        w_issue     = 1'b0;
        w_start_acc = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    elem_d      = 3'd0;
                    addr_d      = '0;
                    op_d        = 1'b0;
                    w_issue     = 1'b1;
                    w_start_acc = 1'b1;
                end
            end
            S_RUN: begin
                if (c_STOP_ON_FAIL && w_mismatch) begin
                    state_d = S_DONE;
                end else if (w_last_op) begin
                    state_d = S_DRAIN;
                end else begin
                    elem_d  = nxt_elem;
                    addr_d  = nxt_addr;
                    op_d    = nxt_op;
                    w_issue = 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The op at the new pointer is what the SRAM sees next cycle.
        w_wr       = (elem_d == 3'd0) || op_d;
        mem_cs_d   = w_issue;
        mem_we_d   = w_issue && w_wr;
        mem_addr_d = w_issue ? addr_d : mem_addr_q;
        mem_din_d  = (w_issue && w_wr) ? {pDATA_WIDTH{op_value(elem_d, op_d)}} : '0;

        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        fail_count_d = fail_count_q;
        if (w_start_acc) begin
            fail_d       = 1'b0;
            fail_addr_d  = '0;
            fail_data_d  = '0;
            fail_count_d = 8'd0;
        end else if (w_mismatch) begin
            fail_d = 1'b1;
            if (fail_count_q != 8'hFF) begin
                fail_count_d = fail_count_q + 8'd1;
            end
            if (!fail_q) begin
                fail_addr_d = chk_addr_q;
                fail_data_d = mem_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            elem_q       <= 3'd0;
            addr_q       <= '0;
            op_q         <= 1'b0;
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            chk_vld_q    <= 1'b0;
            chk_exp_q    <= 1'b0;
            chk_addr_q   <= '0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
            fail_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
            mem_cs_q     <= mem_cs_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            chk_vld_q    <= mem_cs_q && !mem_we_q;
            chk_exp_q    <= op_value(elem_q, op_q);
            chk_addr_q   <= mem_addr_q;
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_data_q  <= fail_data_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done       = (state_q == S_DONE);
    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_data  = fail_data_q;
    assign fail_count = fail_count_q;
    assign mem_cs     = mem_cs_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;

endmodule
`default_nettype wire
